adc_spi_sampler: RTL and testbench
==================================

Name: adc_spi_sampler

Overview:
- SPI master for an external 10-bit, 8-channel serial ADC (MCP3008-style framing). It sits between the ADC pins and the 10-bit Avalon GPIO block.
- Control input is driven from the GPIO block's output port. The converted result drives the GPIO block's input port.
- Software starts conversions by writing control bits and polls for the result, or takes an interrupt on the done pulse.

Parameters:
- CLK_DIV, 25, clk cycles per SCLK half-period; SCLK = clk/(2*CLK_DIV); legal range 2..255.
- CS_GAP, 8, minimum clk cycles adc_cs_n stays high between frames; legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- ctrl  in  10  from GPIO out_port. [0] start (rising edge), [1] continuous, [4:2] channel, [9:5] ignored.
- adc_data  out  10  last completed conversion, to GPIO in_port.
- busy  out  1  frame or inter-frame gap in progress.
- done  out  1  one-clk pulse when adc_data updates.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  ADC serial clock, SPI mode 0.
- adc_mosi  out  1  serial command to ADC.
- adc_miso  in  1  serial data from ADC; asynchronous, double-registered inside the block.

Behaviour:
- Reset: clock clk; reset reset_n, asynchronous, active-low.
  - While reset is asserted: adc_cs_n=1, adc_sclk=0, adc_mosi=0, adc_data=0, busy=0, done=0, FSM in IDLE.
  - Reset mid-frame aborts immediately. No partial result is written to adc_data.
- ctrl is registered once. start_edge = ctrl_q[0] & ~ctrl_q2[0].
- FSM states: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - Trigger is start_edge or ctrl_q[1].
  - On the next clk edge after the trigger: latch channel = ctrl_q[4:2], adc_cs_n=0, busy=1, bit index=0, adc_mosi = bit 0, enter SHIFT.
- SHIFT: 16 bit periods, index 0..15.
  - Each period: adc_sclk low for CLK_DIV clks, then high for CLK_DIV clks.
  - adc_mosi updates at the start of each low phase and holds through the high phase.
  - MOSI sequence, index 0..4: 1 (start), 1 (single-ended), ch[2], ch[1], ch[0]. Index 5..15: 0.
  - MISO sampled on each rising SCLK edge, using the synchronised value.
  - Index 5 is the ADC null bit and is discarded. Index 6..15 shift into a 10-bit register, MSB first (D9..D0).
- HOLD:
  - After bit 15's high phase: adc_sclk=0, adc_mosi=0, hold for CLK_DIV clks.
  - Then adc_cs_n=1, adc_data <= shift register, done=1 for exactly that cycle, enter GAP.
  - adc_cs_n low duration = 33*CLK_DIV clks exactly.
- GAP:
  - CS_GAP clks with adc_cs_n=1, busy=1. Then enter IDLE with busy=0.
  - If ctrl_q[1]=1 on IDLE entry, a new frame starts the following cycle.
- Start/continuous while busy:
  - start_edge while busy is ignored, not queued.
  - Clearing continuous mid-frame completes the current frame; no further frame starts.
- Channel changes in ctrl mid-frame have no effect until the next frame latch.
- adc_data holds its value between frames. adc_data and done are stable for software polling via the GPIO read path.
- MISO synchroniser delay: the ADC must present data at least 2 clks before the rising SCLK edge. This is guaranteed for CLK_DIV>=2 when the ADC updates on the falling edge.
- The SCLK phase counter wraps at CLK_DIV-1. No SCLK glitches on state transitions.

Test Plan:
- Single conversion.
  - Stimulus: CLK_DIV=4, CS_GAP=8, ctrl=0x015 (ch5, start), ADC model returns 0x2A5.
  - Required: MOSI bits 1,1,1,0,1 then zeros; exactly 16 SCLK rises; cs_n low 132 clks; adc_data=0x2A5; done high 1 clk; busy low 8 clks after cs_n rises.
- Boundary data values.
  - Stimulus: ch0 returning 0x000, then ch7 returning 0x3FF.
  - Required: adc_data=0x000 then 0x3FF; ch7 MOSI = 1,1,1,1,1.
- Continuous mode.
  - Stimulus: ctrl=0x00A (continuous, ch2); ADC model returns 0x101, 0x202, 0x303.
  - Required: three back-to-back frames, cs_n high exactly 8 clks between frames, adc_data updates in sequence.
  - Then clear bit1 mid-frame 2: frame 2 completes, no frame 3.
- Start while busy.
  - Stimulus: second start rising edge plus channel change to ch3, issued 40 clks into a frame.
  - Required: no extra frame; channel bits of the in-flight frame unchanged; only one done pulse.
- Reset mid-frame.
  - Stimulus: assert reset_n=0 at SHIFT bit 8.
  - Required: same cycle cs_n=1, sclk=0, mosi=0, busy=0, adc_data=0; after release, a new start runs a normal 132-clk frame.
- Null bit and MISO alignment.
  - Stimulus: ADC model drives 1 during index 5 and 0x155 on data bits.
  - Required: adc_data=0x155, null bit discarded.

Source files
------------

// File: rtl/adc_spi_sampler.sv
// SPI master for an MCP3008-style 10-bit, 8-channel ADC between the pins and a GPIO block.
// Latency: trigger -> cs_n low next clk; cs_n low 33*CLK_DIV clks; result + done on cs_n rise.
// Backpressure: none; start edges arriving while busy are dropped, continuous re-arms after the gap.
module adc_spi_sampler #(
  parameter int CLK_DIV = 25,  // clk cycles per SCLK half-period, 2..255
  parameter int CS_GAP  = 8    // minimum cs_n high clks between frames, 1..255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] ctrl,
  output logic [9:0] adc_data,
  output logic       busy,
  output logic       done,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       adc_mosi,
  input  logic       adc_miso
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  // Control word (only the low five bits carry meaning) and edge-detect history.
  logic [4:0] ctrl_q;
  logic       start_q2;

  // MISO two-flop synchroniser.
  logic       miso_s1_q;
  logic       miso_s2_q;

  // Frame state.
  state_t     state_q;
  logic [7:0] div_cnt_q;
  logic [7:0] gap_cnt_q;
  logic [3:0] bit_idx_q;
  logic [2:0] ch_q;
  logic [9:0] shreg_q;

  // Registered outputs.
  logic       cs_n_q;
  logic       sclk_q;
  logic       mosi_q;
  logic [9:0] data_q;
  logic       busy_q;
  logic       done_q;

  // Combinational helpers.
  logic       start_edge;
  logic       launch_d;
  logic       mosi_d;
  logic [3:0] next_idx;

  // Upper control bits are reserved by the GPIO map and deliberately ignored.
  logic       ctrl_unused;
  assign ctrl_unused = ^ctrl[9:5];

  assign adc_data = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign adc_cs_n = cs_n_q;
  assign adc_sclk = sclk_q;
  assign adc_mosi = mosi_q;

  // Register the GPIO control word once and keep the previous start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= '0;
      start_q2 <= 1'b0;
    end else begin
      ctrl_q   <= ctrl[4:0];
      start_q2 <= ctrl_q[0];
    end
  end

  // Bring the asynchronous MISO pin into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= adc_miso;
      miso_s2_q <= miso_s1_q;
    end
  end

  // Frame launch decision and the command bit for the next SCLK period.
  always_comb begin
    start_edge = ctrl_q[0] & ~start_q2;
    next_idx   = bit_idx_q + 4'd1;
    // From IDLE either trigger starts a frame; at the end of the gap only
    // continuous mode re-launches, so back-to-back frames see exactly CS_GAP
    // high clks on cs_n and a start edge during the gap is simply dropped.
    launch_d   = ((state_q == IDLE) && (ctrl_q[1] || start_edge)) ||
                 ((state_q == GAP) && (gap_cnt_q == GAP_LAST) && ctrl_q[1]);
    mosi_d     = 1'b0;
    case (next_idx)
      4'd1:    mosi_d = 1'b1;      // single-ended
      4'd2:    mosi_d = ch_q[2];
      4'd3:    mosi_d = ch_q[1];
      4'd4:    mosi_d = ch_q[0];
      default: mosi_d = 1'b0;
    endcase
  end

  // Frame FSM: IDLE -> SHIFT (16 SCLK periods) -> HOLD -> GAP -> IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      gap_cnt_q <= '0;
      bit_idx_q <= '0;
      ch_q      <= '0;
      shreg_q   <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          div_cnt_q <= '0;
        end
        SHIFT: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            if (!sclk_q) begin
              // Rising SCLK: index 5 is the null bit, 6..15 carry D9..D0.
              sclk_q <= 1'b1;
              if (bit_idx_q >= 4'd6) begin
                shreg_q <= {shreg_q[8:0], miso_s2_q};
              end
            end else begin
              // Falling SCLK starts the next period's low phase.
              sclk_q <= 1'b0;
              if (bit_idx_q == 4'd15) begin
                mosi_q  <= 1'b0;
                state_q <= HOLD;
              end else begin
                bit_idx_q <= next_idx;
                mosi_q    <= mosi_d;
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            cs_n_q    <= 1'b1;
            data_q    <= shreg_q;
            done_q    <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= GAP;
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
      // A launch overrides the per-state updates above.
      if (launch_d) begin
        state_q   <= SHIFT;
        ch_q      <= ctrl_q[4:2];
        cs_n_q    <= 1'b0;
        busy_q    <= 1'b1;
        bit_idx_q <= '0;
        div_cnt_q <= '0;
        sclk_q    <= 1'b0;
        mosi_q    <= 1'b1;  // start bit
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed self-checking bench for adc_spi_sampler with CLK_DIV=4, CS_GAP=8.
// A negedge-clk monitor doubles as the ADC model and records frame timing.
// Each scenario task applies stimulus and compares against hand-computed values.
module tb_adc_spi_sampler;
  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] ctrl = '0;
  logic [9:0] adc_data;
  logic       busy;
  logic       done;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic       adc_mosi;
  logic       adc_miso = 1'b0;

  always #5 clk = ~clk;

  adc_spi_sampler #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ctrl     (ctrl),
    .adc_data (adc_data),
    .busy     (busy),
    .done     (done),
    .adc_cs_n (adc_cs_n),
    .adc_sclk (adc_sclk),
    .adc_mosi (adc_mosi),
    .adc_miso (adc_miso)
  );

  int vecs = 0;
  int errs = 0;

  // Monitor / ADC model state.
  int          cyc = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_busy = 1'b0;
  int          cs_cnt = 0;
  int          cs_low_len = 0;
  int          cs_high_len = 0;
  int          cs_rise_cyc = 0;
  int          busy_gap = 0;
  int          frame_cnt = 0;
  int          rise_cnt = 0;
  int          fall_idx = 0;
  int          done_total = 0;
  int          done_in_frame = 0;
  logic [15:0] mosi_word = '0;
  logic [9:0]  resp_q[$];
  logic [9:0]  cur_resp = '0;
  logic        null_val = 1'b1;

  function automatic logic miso_for(input int i, input logic [9:0] r, input logic nb);
    if (i == 5) return nb;
    if (i >= 6 && i <= 15) return r[15 - i];
    return 1'b0;
  endfunction

  // ADC model (drives MISO after each SCLK fall) and frame-timing monitor.
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_cs   <= adc_cs_n;
    prev_sclk <= adc_sclk;
    prev_busy <= busy;
    if (prev_cs && !adc_cs_n) begin
      frame_cnt     <= frame_cnt + 1;
      if (frame_cnt > 0) cs_high_len <= cs_cnt;
      cs_cnt        <= 1;
      rise_cnt      <= 0;
      mosi_word     <= '0;
      done_in_frame <= 0;
      fall_idx      <= 0;
      adc_miso      <= 1'b0;
      if (resp_q.size() > 0) cur_resp <= resp_q.pop_front();
    end else if (!prev_cs && adc_cs_n) begin
      cs_low_len  <= cs_cnt;
      cs_cnt      <= 1;
      cs_rise_cyc <= cyc;
      adc_miso    <= 1'b0;
    end else begin
      cs_cnt <= cs_cnt + 1;
    end
    if (!adc_cs_n && !prev_sclk && adc_sclk) begin
      rise_cnt <= rise_cnt + 1;
      if (rise_cnt < 16) mosi_word[15 - rise_cnt] <= adc_mosi;
    end
    if (!adc_cs_n && prev_sclk && !adc_sclk) begin
      fall_idx <= fall_idx + 1;
      adc_miso <= miso_for(fall_idx + 1, cur_resp, null_val);
    end
    if (done) begin
      done_total    <= done_total + 1;
      done_in_frame <= done_in_frame + 1;
    end
    if (prev_busy && !busy) busy_gap <= cyc - cs_rise_cyc;
  end

  task automatic set_ctrl(input logic [9:0] v);
    @(posedge clk);
    #1 ctrl = v;
  endtask

  task automatic wait_frames(input int target, input int budget, input string what);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (frame_cnt >= target) return;
    end
    vecs++; errs++;
    $display("FAIL %s: timeout, frames=%0d required=%0d", what, frame_cnt, target);
  endtask

  task automatic wait_dones(input int target, input int budget, input string what);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (done_total >= target) return;
    end
    vecs++; errs++;
    $display("FAIL %s: timeout, dones=%0d required=%0d", what, done_total, target);
  endtask

  task automatic wait_rises(input int target, input int budget, input string what);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (rise_cnt >= target) return;
    end
    vecs++; errs++;
    $display("FAIL %s: timeout, rises=%0d required=%0d", what, rise_cnt, target);
  endtask

  task automatic wait_idle(input int budget, input string what);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (!busy) return;
    end
    vecs++; errs++;
    $display("FAIL %s: timeout, busy still high", what);
  endtask

  // One single-shot frame: pulse start with the given ctrl word, wait for result and idle.
  task automatic run_single(input logic [9:0] c, input logic [9:0] r);
    int d0;
    d0 = done_total;
    resp_q.push_back(r);
    set_ctrl(c);
    repeat (3) @(posedge clk);
    #1 ctrl = c & 10'h3FE;
    wait_dones(d0 + 1, 400, "frame done");
    wait_idle(50, "frame idle");
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    ctrl    = '0;
    repeat (3) @(negedge clk);
    vecs++; if (adc_cs_n !== 1'b1) begin errs++; $display("FAIL rst_cs_n: got %b want 1", adc_cs_n); end
    vecs++; if (adc_sclk !== 1'b0) begin errs++; $display("FAIL rst_sclk: got %b want 0", adc_sclk); end
    vecs++; if (adc_mosi !== 1'b0) begin errs++; $display("FAIL rst_mosi: got %b want 0", adc_mosi); end
    vecs++; if (adc_data !== 10'h000) begin errs++; $display("FAIL rst_data: got %h want 000", adc_data); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b want 0", done); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_single;
    run_single(10'h015, 10'h2A5);
    vecs++; if (adc_data !== 10'h2A5) begin errs++; $display("FAIL single_data: got %h want 2a5", adc_data); end
    vecs++; if (mosi_word !== 16'hE800) begin errs++; $display("FAIL single_mosi: got %h want e800", mosi_word); end
    vecs++; if (rise_cnt !== 16) begin errs++; $display("FAIL single_rises: got %0d want 16", rise_cnt); end
    vecs++; if (cs_low_len !== 132) begin errs++; $display("FAIL single_cs_low: got %0d want 132", cs_low_len); end
    vecs++; if (done_in_frame !== 1) begin errs++; $display("FAIL single_done_len: got %0d want 1", done_in_frame); end
    vecs++; if (busy_gap !== 8) begin errs++; $display("FAIL single_busy_gap: got %0d want 8", busy_gap); end
    repeat (20) @(posedge clk);
    vecs++; if (adc_data !== 10'h2A5) begin errs++; $display("FAIL single_hold: got %h want 2a5", adc_data); end
  endtask

  task automatic test_boundary;
    run_single(10'h001, 10'h000);
    vecs++; if (adc_data !== 10'h000) begin errs++; $display("FAIL ch0_data: got %h want 000", adc_data); end
    vecs++; if (mosi_word !== 16'hC000) begin errs++; $display("FAIL ch0_mosi: got %h want c000", mosi_word); end
    run_single(10'h01D, 10'h3FF);
    vecs++; if (adc_data !== 10'h3FF) begin errs++; $display("FAIL ch7_data: got %h want 3ff", adc_data); end
    vecs++; if (mosi_word !== 16'hF800) begin errs++; $display("FAIL ch7_mosi: got %h want f800", mosi_word); end
    vecs++; if (cs_low_len !== 132) begin errs++; $display("FAIL ch7_cs_low: got %0d want 132", cs_low_len); end
    set_ctrl(10'h000);
  endtask

  task automatic test_continuous(input int n, input logic [9:0] r0, input logic [9:0] r1, input logic [9:0] r2);
    int f0, d0;
    logic [9:0] exp_v;
    f0 = frame_cnt;
    d0 = done_total;
    resp_q.push_back(r0);
    resp_q.push_back(r1);
    if (n > 2) resp_q.push_back(r2);
    set_ctrl(10'h00A);
    for (int i = 0; i < n; i++) begin
      wait_frames(f0 + i + 1, 400, "cont_start");
      if (i == n - 1) begin
        repeat (40) @(posedge clk);
        #1 ctrl = 10'h008;
      end
      wait_dones(d0 + i + 1, 400, "cont_done");
      exp_v = (i == 0) ? r0 : ((i == 1) ? r1 : r2);
      vecs++; if (adc_data !== exp_v) begin errs++; $display("FAIL cont_data%0d: got %h want %h", i, adc_data, exp_v); end
      if (i > 0) begin
        vecs++; if (cs_high_len !== 8) begin errs++; $display("FAIL cont_gap%0d: got %0d want 8", i, cs_high_len); end
      end
    end
    wait_idle(50, "cont_idle");
    repeat (200) @(posedge clk);
    vecs++; if (frame_cnt - f0 !== n) begin errs++; $display("FAIL cont_frames: got %0d want %0d", frame_cnt - f0, n); end
    vecs++; if (done_total - d0 !== n) begin errs++; $display("FAIL cont_dones: got %0d want %0d", done_total - d0, n); end
    set_ctrl(10'h000);
  endtask

  task automatic test_start_while_busy;
    int f0, d0;
    f0 = frame_cnt;
    d0 = done_total;
    resp_q.push_back(10'h1C3);
    set_ctrl(10'h011);
    repeat (3) @(posedge clk);
    #1 ctrl = 10'h010;
    wait_frames(f0 + 1, 50, "busy_start");
    repeat (40) @(posedge clk);
    #1 ctrl = 10'h00D;
    wait_dones(d0 + 1, 400, "busy_done");
    wait_idle(50, "busy_idle");
    repeat (200) @(posedge clk);
    vecs++; if (frame_cnt - f0 !== 1) begin errs++; $display("FAIL busy_frames: got %0d want 1", frame_cnt - f0); end
    vecs++; if (done_total - d0 !== 1) begin errs++; $display("FAIL busy_dones: got %0d want 1", done_total - d0); end
    vecs++; if (mosi_word !== 16'hE000) begin errs++; $display("FAIL busy_mosi: got %h want e000", mosi_word); end
    vecs++; if (adc_data !== 10'h1C3) begin errs++; $display("FAIL busy_data: got %h want 1c3", adc_data); end
    set_ctrl(10'h000);
  endtask

  task automatic test_reset_mid;
    int f0;
    f0 = frame_cnt;
    resp_q.push_back(10'h0AA);
    set_ctrl(10'h019);
    repeat (3) @(posedge clk);
    #1 ctrl = 10'h018;
    wait_frames(f0 + 1, 50, "rmid_start");
    wait_rises(9, 200, "rmid_bit8");
    @(posedge clk);
    #1 reset_n = 1'b0;
    ctrl = 10'h000;
    #1;
    vecs++; if (adc_cs_n !== 1'b1) begin errs++; $display("FAIL rmid_cs_n: got %b want 1", adc_cs_n); end
    vecs++; if (adc_sclk !== 1'b0) begin errs++; $display("FAIL rmid_sclk: got %b want 0", adc_sclk); end
    vecs++; if (adc_mosi !== 1'b0) begin errs++; $display("FAIL rmid_mosi: got %b want 0", adc_mosi); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy: got %b want 0", busy); end
    vecs++; if (adc_data !== 10'h000) begin errs++; $display("FAIL rmid_data: got %h want 000", adc_data); end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    run_single(10'h015, 10'h2A5);
    vecs++; if (cs_low_len !== 132) begin errs++; $display("FAIL rmid_cs_low: got %0d want 132", cs_low_len); end
    vecs++; if (adc_data !== 10'h2A5) begin errs++; $display("FAIL rmid_new_data: got %h want 2a5", adc_data); end
    vecs++; if (done_in_frame !== 1) begin errs++; $display("FAIL rmid_done_len: got %0d want 1", done_in_frame); end
    set_ctrl(10'h000);
  endtask

  task automatic test_null_bit;
    null_val = 1'b1;
    run_single(10'h001, 10'h155);
    vecs++; if (adc_data !== 10'h155) begin errs++; $display("FAIL null_data: got %h want 155", adc_data); end
    set_ctrl(10'h000);
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_continuous(3, 10'h101, 10'h202, 10'h303);
    test_continuous(2, 10'h3C0, 10'h03F, 10'h000);
    test_start_while_busy();
    test_reset_mid();
    test_null_bit();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
